cache_array_ctl: RTL and testbench
==================================

// Module: cache_array_ctl
// PURPOSE
//  Parametrised byte-enabled 1W1R cache data array with registered read, write-to-read bypass,
//  and a hardware clear sequencer. Sits under the L1 I/D cache tag/data logic, replacing
//  fixed 1024x32 arrays. Clears all rows after reset or on invalidate so tags/data start known.
// PARAMETERS
//  WIDTH       32    data bits per row; multiple of 8; BYTES = WIDTH/8
//  ROWS        1024  rows; power of 2, 4..4096; ADR_W = $clog2(ROWS)
//  CLR_ON_RST  1     1: clear sequence starts automatically on reset release
//  BYPASS      1     1: same-cycle write to read address forwarded to read data
// PORTS
//  clk      in   1       clock, all state on rising edge
//  rst_n    in   1       asynchronous active-low reset
//  inv_req  in   1       start clear sequence (pulse)
//  busy     out  1       clear in progress; rd/wr ignored
//  rd_en    in   1       read request
//  rd_adr   in   ADR_W   read row
//  rd_vld   out  1       rd_dat valid this cycle
//  rd_dat   out  WIDTH   read data
//  wr_en    in   BYTES   per-byte write enable
//  wr_adr   in   ADR_W   write row
//  wr_dat   in   WIDTH   write data
// BEHAVIOUR
//  - Reset (async, rst_n=0): busy=CLR_ON_RST, rd_vld=0, rd_dat=0, row counter=0.
//    Array contents are not reset.
//  - FSM states:
//      IDLE -> CLEAR on inv_req, or on the first edge after reset release if CLR_ON_RST.
//      CLEAR: writes all-zero to row cnt, cnt++ each cycle.
//      CLEAR -> IDLE after row ROWS-1 is written. A clear takes exactly ROWS cycles.
//      busy=1 for all of CLEAR.
//  - inv_req during CLEAR: counter restarts at 0; the sequence is extended.
//  - inv_req in IDLE with rd_en or wr_en in the same cycle: inv wins; rd/wr dropped; rd_vld=0 next cycle.
//  - While busy: rd_en and wr_en are ignored; rd_vld=0; rd_dat holds its last value.
//  - Read: rd_en at cycle N with busy=0 -> rd_vld=1 and rd_dat=mem[rd_adr] at N+1.
//    rd_vld=0 when rd_en=0; rd_dat holds its last value.
//  - Write: for each lane b with wr_en[b]=1, mem[wr_adr][8b+7:8b] <= wr_dat lane b. Lanes with wr_en[b]=0 are unchanged.
//  - Same-cycle read and write to the same row:
//      BYPASS=1: rd_dat lane b = wr_dat lane b if wr_en[b]=1, else the old mem lane.
//      BYPASS=0: rd_dat returns the old data.
//    Different rows: independent, no interaction.
//  - Write at N, read of the same row at N+1: returns the new data (array write completes at edge N).
//  - Counter wraps naturally at ROWS; the last clear row is detected by cnt==ROWS-1, not by overflow.
//  - Reset asserted mid-clear: aborts immediately; the sequence restarts from row 0 on release if CLR_ON_RST.
//    Otherwise rows are left partially cleared.
// STRUCTURE
//  - defs.v: add `define CACHE_ST_IDLE / `CACHE_ST_CLEAR encodings; add a `CACHE_ARRAY_CTL select alongside existing EXPAND_TYPE values.
//  - Sub-module cache_clr_fsm (inputs: clk, rst_n, inv_req; outputs: busy, clr_we, clr_adr).
//    Top muxes the clear write onto the array write port.
//  - Array is inferred, with a per-lane write loop; hard-macro substitution comes later behind the same port list.
// TESTING
//  1. Reset release, CLR_ON_RST=1, ROWS=16:
//     busy=1 for exactly 16 cycles. Then a read of each of rows 0..15 -> rd_dat=0, rd_vld=1 one cycle later.
//  2. wr_en=4'b0101, wr_adr=3, wr_dat=32'hAABBCCDD on a cleared row; read row 3 -> 32'h00BB00DD.
//  3. BYPASS=1: row 5 = 32'h11223344; same cycle wr_en=4'b1000, wr_dat=32'hFF000000, rd row 5
//     -> next cycle rd_dat=32'hFF223344. BYPASS=0 -> 32'h11223344.
//  4. inv_req at clear row 7 of 16 -> busy stays high 16 more cycles.
//     A rd_en during busy -> rd_vld=0 and rd_dat unchanged.
//  5. rst_n low at clear row 9, held 2 cycles, released -> busy=1 for 16 cycles, then all rows read 0.
//  6. Back-to-back: write row 2 at N, read row 2 at N+1 -> new data at N+2.
//     rd_en=0 cycles -> rd_vld=0.

Source files
------------

// File: rtl/cache_array_ctl_pkg.sv
// rtl/cache_array_ctl_pkg.sv - shared state encodings and lane helper for the cache data array
package cache_array_ctl_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    function automatic logic [7:0] lane_sel(input logic en, input logic [7:0] new_b,
                                            input logic [7:0] old_b);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/cache_clr_fsm.sv
// rtl/cache_clr_fsm.sv - clear sequencer walking every row once after reset or invalidate
module cache_clr_fsm #(
    parameter  int ROWS       = 1024,
    parameter  bit CLR_ON_RST = 1'b1,
    localparam int ADR_W      = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inv_req,
    output logic             busy,
    output logic             clr_we,
    output logic [ADR_W-1:0] clr_adr
);
    import cache_array_ctl_pkg::*;

    localparam logic [ADR_W-1:0] LAST_ROW = ADR_W'(ROWS - 1);

    logic [0:0]       state_q, state_d;
    logic [ADR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (inv_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                // A fresh invalidate restarts the walk so every row is covered after it.
                if (inv_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADR_W'(1);
                end
            end
        endcase
    end

    // Resetting straight into CLEAR makes busy visible during reset and row 0 written on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q == ST_CLEAR);
    assign clr_we  = busy;
    assign clr_adr = cnt_q;

endmodule

// File: rtl/cache_array_ctl.sv
// rtl/cache_array_ctl.sv - byte-enabled 1W1R cache data array with registered read, bypass and clear
module cache_array_ctl #(
    parameter  int WIDTH      = 32,
    parameter  int ROWS       = 1024,
    parameter  bit CLR_ON_RST = 1'b1,
    parameter  bit BYPASS     = 1'b1,
    localparam int BYTES      = WIDTH / 8,
    localparam int ADR_W      = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inv_req,
    output logic             busy,
    input  logic             rd_en,
    input  logic [ADR_W-1:0] rd_adr,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic [BYTES-1:0] wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [WIDTH-1:0] wr_dat
);
    import cache_array_ctl_pkg::*;

    logic             clr_we;
    logic [ADR_W-1:0] clr_adr;

    cache_clr_fsm #(
        .ROWS       (ROWS),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .inv_req (inv_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_adr (clr_adr)
    );

    logic [WIDTH-1:0] mem_q [ROWS];

    logic             rd_acc;
    logic [BYTES-1:0] wr_acc;
    logic [BYTES-1:0] arr_we;
    logic [ADR_W-1:0] arr_adr;
    logic [WIDTH-1:0] arr_dat;
    logic [WIDTH-1:0] rd_word;
    logic             rd_vld_q, rd_vld_d;
    logic [WIDTH-1:0] rd_dat_q, rd_dat_d;

    // Invalidate wins over a same-cycle access even while still idle.
    assign rd_acc = rd_en & ~busy & ~inv_req;
    assign wr_acc = (busy | inv_req) ? '0 : wr_en;

    always_comb begin
        arr_we  = wr_acc;
        arr_adr = wr_adr;
        arr_dat = wr_dat;
        if (clr_we) begin
            arr_we  = '1;
            arr_adr = clr_adr;
            arr_dat = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (arr_we[b]) begin
                mem_q[arr_adr][8*b +: 8] <= arr_dat[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem_q[rd_adr];
        if (BYPASS && (wr_adr == rd_adr)) begin
            for (int b = 0; b < BYTES; b++) begin
                rd_word[8*b +: 8] = lane_sel(wr_acc[b], wr_dat[8*b +: 8], mem_q[rd_adr][8*b +: 8]);
            end
        end
        rd_vld_d = rd_acc;
        rd_dat_d = rd_acc ? rd_word : rd_dat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_vld = rd_vld_q;
    assign rd_dat = rd_dat_q;

endmodule

// File: tb/tb_cache_array_ctl.sv
// tb/tb_cache_array_ctl.sv - directed table-driven bench for cache_array_ctl (ROWS=16)
module tb_cache_array_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inv_req;
    logic        rd_en;
    logic [3:0]  rd_adr;
    logic [3:0]  wr_en;
    logic [3:0]  wr_adr;
    logic [31:0] wr_dat;
    logic        busy, busy_nb;
    logic        rd_vld, rd_vld_nb;
    logic [31:0] rd_dat, rd_dat_nb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_array_ctl #(.WIDTH(32), .ROWS(16), .CLR_ON_RST(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .inv_req(inv_req), .busy(busy),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dat(rd_dat),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat)
    );

    cache_array_ctl #(.WIDTH(32), .ROWS(16), .CLR_ON_RST(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .inv_req(inv_req), .busy(busy_nb),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_vld(rd_vld_nb), .rd_dat(rd_dat_nb),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat)
    );

    typedef struct {
        logic [3:0]  we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [31:0] ed;
        logic [31:0] ed_nb;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic [3:0] we, logic [3:0] wa, logic [31:0] wd, logic re,
                                logic [3:0] ra, logic ev, logic [31:0] ed, logic [31:0] ed_nb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.ev = ev; v.ed = ed; v.ed_nb = ed_nb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic re, input logic [3:0] ra, input logic inv);
        wr_en = we; wr_adr = wa; wr_dat = wd; rd_en = re; rd_adr = ra; inv_req = inv;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    task automatic read_all_zero(input string name);
        for (int r = 0; r < 16; r++) begin
            drive(4'h0, 4'h0, 32'h0, 1'b1, 4'(r), 1'b0);
            step();
            chk({name, "_vld"}, {31'h0, rd_vld}, 32'h1);
            chk({name, "_dat"}, rd_dat, 32'h0);
        end
        drive(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = mk(4'h0, 4'h0, 32'h0, 1'b1, 4'(i), 1'b1, 32'h0, 32'h0);
        tbl[16] = mk(4'b0101, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0, 1'b0, 32'h00000000, 32'h00000000);
        tbl[17] = mk(4'b0000, 4'd0, 32'h0,        1'b1, 4'd3, 1'b1, 32'h00BB00DD, 32'h00BB00DD);
        tbl[18] = mk(4'b1111, 4'd2, 32'h12345678, 1'b0, 4'd0, 1'b0, 32'h00BB00DD, 32'h00BB00DD);
        tbl[19] = mk(4'b0000, 4'd0, 32'h0,        1'b1, 4'd2, 1'b1, 32'h12345678, 32'h12345678);
        tbl[20] = mk(4'b0000, 4'd0, 32'h0,        1'b0, 4'd2, 1'b0, 32'h12345678, 32'h12345678);
        tbl[21] = mk(4'b1111, 4'd5, 32'h11223344, 1'b0, 4'd0, 1'b0, 32'h12345678, 32'h12345678);
        tbl[22] = mk(4'b1000, 4'd5, 32'hFF000000, 1'b1, 4'd5, 1'b1, 32'hFF223344, 32'h11223344);
        tbl[23] = mk(4'b0000, 4'd0, 32'h0,        1'b1, 4'd5, 1'b1, 32'hFF223344, 32'hFF223344);
        tbl[24] = mk(4'b1111, 4'd6, 32'hAAAA5555, 1'b1, 4'd3, 1'b1, 32'h00BB00DD, 32'h00BB00DD);
        tbl[25] = mk(4'b0000, 4'd0, 32'h0,        1'b1, 4'd6, 1'b1, 32'hAAAA5555, 32'hAAAA5555);

        rst_n = 1'b0;
        drive(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        step();
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_rd_vld", {31'h0, rd_vld}, 32'h0);
        chk("rst_rd_dat", rd_dat, 32'h0);
        step();
        rst_n = 1'b1;
        count_busy("rst_clear_len");
        chk("nb_idle_after_clear", {31'h0, busy_nb}, 32'h0);

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, 1'b0);
            step();
            chk($sformatf("vec%0d_vld", i), {31'h0, rd_vld}, {31'h0, tbl[i].ev});
            chk($sformatf("vec%0d_dat", i), rd_dat, tbl[i].ed);
            chk($sformatf("vec%0d_vld_nb", i), {31'h0, rd_vld_nb}, {31'h0, tbl[i].ev});
            chk($sformatf("vec%0d_dat_nb", i), rd_dat_nb, tbl[i].ed_nb);
        end

        // invalidate with a simultaneous read and write: both dropped
        drive(4'b1111, 4'd9, 32'h99999999, 1'b1, 4'd3, 1'b1);
        step();
        chk("inv_busy", {31'h0, busy}, 32'h1);
        chk("inv_drop_vld", {31'h0, rd_vld}, 32'h0);
        chk("inv_drop_dat", rd_dat, 32'hAAAA5555);
        drive(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        chk("inv_mid_busy", {31'h0, busy}, 32'h1);
        drive(4'h0, 4'h0, 32'h0, 1'b1, 4'd6, 1'b1);
        step();
        chk("busy_rd_vld", {31'h0, rd_vld}, 32'h0);
        chk("busy_rd_dat", rd_dat, 32'hAAAA5555);
        drive(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        count_busy("inv_restart_len");
        read_all_zero("inv_cleared");

        drive(4'b1111, 4'd12, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0);
        step();
        drive(4'h0, 4'h0, 32'h0, 1'b1, 4'd12, 1'b0);
        step();
        chk("pre_rst_dat", rd_dat, 32'hDEADBEEF);

        // reset asserted at clear row 9
        drive(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1);
        step();
        drive(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_busy", {31'h0, busy}, 32'h1);
        chk("midclr_rst_dat", rd_dat, 32'h0);
        chk("midclr_rst_vld", {31'h0, rd_vld}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        count_busy("midclr_restart_len");
        read_all_zero("midclr_cleared");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
